veda_mem_3: RTL and testbench
=============================

# veda_mem_3

Parametrised dual-address scratch memory. It succeeds the fixed 64x8 `veda_mem_2` and is built from registers. It adds four command modes (read, write-with-read, accumulate, copy), a post-reset hardware clear sequence, and `busy`/`valid` handshake outputs. It sits behind the datapath as a small working store that a controller drives one command per cycle.

## Interface
Parameters:
- `DATA_W`, 8: word width in bits.
- `ADDR_W`, 6: address width in bits.
- `DEPTH`, 2**ADDR_W: number of words. `DEPTH` ≤ 2**ADDR_W.

Ports:
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst`, input, 1: reset, synchronous, active-low.
- `we`, input, 1: command enable for write-type modes.
- `Mode`, input, 2: command select. 00 READ, 01 WRITE, 10 ACC, 11 COPY.
- `address_a`, input, `ADDR_W`: destination / write address.
- `address_b`, input, `ADDR_W`: source / read address.
- `dataIn`, input, `DATA_W`: write or addend data.
- `dataOut`, output, `DATA_W`: registered result. Holds its value when `valid`=0.
- `valid`, output, 1: one-cycle pulse; `dataOut` is new this cycle.
- `busy`, output, 1: high while commands are ignored.

## Operation
- States: CLEAR, IDLE, COPY2.
- Reset, sampled on an edge with `rst`=0:
  - state ← CLEAR; clear counter ← 0.
  - `dataOut` ← 0, `valid` ← 0, `busy` ← 1.
  - Memory contents are not touched that edge.
- CLEAR:
  - Each edge with `rst`=1 writes word[counter] ← 0 and increments the counter.
  - After word `DEPTH`-1 is written, the next state is IDLE and `busy` falls.
  - Commands presented during CLEAR are ignored.
- IDLE accepts one command per edge:
  - READ: `dataOut` ← mem[`address_b`], `valid` ← 1. `we` is ignored.
  - WRITE: `dataOut` ← mem[`address_b`] and `valid` ← 1, regardless of `we`. If `we`=1, mem[`address_a`] ← `dataIn`. When `address_a` == `address_b`, `dataOut` returns the old word (read-before-write).
  - ACC, `we`=1: sum = mem[`address_a`] + `dataIn`, modulo 2**`DATA_W` (carry discarded). Then mem[`address_a`] ← sum, `dataOut` ← sum, `valid` ← 1.
  - ACC, `we`=0: no operation, `valid` ← 0.
  - COPY, `we`=1: latch mem[`address_b`] and `address_a` internally. State ← COPY2, `busy` ← 1, `valid` ← 0.
  - COPY, `we`=0: no operation.
- COPY2, one cycle:
  - mem[latched a] ← latched word; `dataOut` ← latched word; `valid` ← 1.
  - State ← IDLE; `busy` ← 0.
  - Inputs on this edge are ignored.
  - `address_a` == `address_b` is legal and rewrites the same value.
- Addresses ≥ `DEPTH`: writes are dropped and reads return 0. `valid` still pulses for READ, WRITE and ACC.
- `rst`=0 overrides everything in any state. This includes mid-COPY, where the pending write is discarded and the clear restarts from word 0.

## Timing
- READ, WRITE and ACC have 1-cycle latency: command at edge N gives `dataOut`/`valid` after edge N.
- COPY has 2-cycle latency: `busy`=1 for exactly one cycle, and `valid` pulses after edge N+1.
- A write at edge N is visible to a read at edge N+1. Back-to-back ACC on the same address chains correctly.
- The clear takes `DEPTH` edges after the first edge with `rst`=1. `busy` is 1 from the reset edge through the last clear edge.
- `valid` is never high in two consecutive cycles unless two commands were accepted consecutively.

## Test plan
- Reset and clear:
  - Stimulus: `rst`=0 for 2 cycles, then 1.
  - Required: `dataOut`=0, `valid`=0, `busy`=1 for 64 cycles.
  - Then READ b=20 → `dataOut`=0x00, `valid` pulse.
- WRITE read-before-write:
  - Stimulus: WRITE `we`=1, a=b=20, `dataIn`=0x55.
  - Required: `dataOut`=0x00. Next READ b=20 → 0x55.
  - With `we`=0, a=20, `dataIn`=0x57: mem[20] stays 0x55.
- ACC wrap:
  - Stimulus: ACC `we`=1, a=20, `dataIn`=0xF0, issued twice back-to-back.
  - Required: `dataOut` 0x45, then 0x35, `valid` high both cycles.
- COPY:
  - Stimulus: COPY `we`=1, a=26, b=20.
  - Required: `busy`=1 for one cycle; `valid` one cycle later with 0x35.
  - A WRITE presented during `busy` is ignored. READ b=26 → 0x35.
- Reset mid-COPY:
  - Stimulus: COPY a=23, b=20, then `rst`=0 during COPY2.
  - Required: `valid`=0, `dataOut`=0, full clear re-runs.
  - READ 23 → 0x00.
- Out-of-range with `DEPTH`=40:
  - Stimulus: WRITE `we`=1, a=45, `dataIn`=0xAA.
  - Required: no write. READ b=45 → 0x00 with `valid` pulse.

Source files
------------

// File: rtl/veda_mem_3.sv
// veda_mem_3: register-based dual-address scratch memory with read,
// write-with-read, accumulate and two-cycle copy commands, a hardware
// clear sequence after reset, and busy/valid handshake outputs.
module veda_mem_3 #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [1:0]        Mode,
    input  logic [ADDR_W-1:0] address_a,
    input  logic [ADDR_W-1:0] address_b,
    input  logic [DATA_W-1:0] dataIn,
    output logic [DATA_W-1:0] dataOut,
    output logic              valid,
    output logic              busy
);

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        COPY2 = 2'd2
    } state_t;

    localparam logic [1:0] MODE_READ  = 2'b00;
    localparam logic [1:0] MODE_WRITE = 2'b01;
    localparam logic [1:0] MODE_ACC   = 2'b10;
    localparam logic [1:0] MODE_COPY  = 2'b11;

    // One extra bit so DEPTH itself is representable when DEPTH == 2**ADDR_W.
    localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH-1);

    state_t              stateQ;
    logic [ADDR_W-1:0]   clrCntQ;
    logic [DATA_W-1:0]   dataOutQ;
    logic                validQ;
    logic                busyQ;
    logic [ADDR_W-1:0]   copyAddrQ;
    logic [DATA_W-1:0]   copyDataQ;
    logic [DATA_W-1:0]   memQ [DEPTH];

    logic                inRangeAD;
    logic                inRangeBD;
    logic                inRangeCopyD;
    logic [DATA_W-1:0]   wordAD;
    logic [DATA_W-1:0]   wordBD;
    logic [DATA_W-1:0]   sumD;

    // Range-checked word fetches; out-of-range addresses read as zero.
    always_comb begin
        inRangeAD    = ({1'b0, address_a} < DEPTH_W);
        inRangeBD    = ({1'b0, address_b} < DEPTH_W);
        inRangeCopyD = ({1'b0, copyAddrQ} < DEPTH_W);
        wordAD       = '0;
        wordBD       = '0;
        if (inRangeAD) wordAD = memQ[address_a];
        if (inRangeBD) wordBD = memQ[address_b];
        sumD         = wordAD + dataIn;
    end

    // Control FSM, registered outputs and storage writes; reset leaves the array untouched.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stateQ   <= CLEAR;
            clrCntQ  <= '0;
            dataOutQ <= '0;
            validQ   <= 1'b0;
            busyQ    <= 1'b1;
        end else begin
            validQ <= 1'b0;
            case (stateQ)
                CLEAR: begin
                    memQ[clrCntQ] <= '0;
                    clrCntQ       <= clrCntQ + 1'b1;
                    if (clrCntQ == LAST_WORD) begin
                        stateQ <= IDLE;
                        busyQ  <= 1'b0;
                    end
                end
                IDLE: begin
                    case (Mode)
                        MODE_READ: begin
                            dataOutQ <= wordBD;
                            validQ   <= 1'b1;
                        end
                        MODE_WRITE: begin
                            dataOutQ <= wordBD;
                            validQ   <= 1'b1;
                            if (we && inRangeAD) memQ[address_a] <= dataIn;
                        end
                        MODE_ACC: begin
                            if (we) begin
                                dataOutQ <= sumD;
                                validQ   <= 1'b1;
                                if (inRangeAD) memQ[address_a] <= sumD;
                            end
                        end
                        MODE_COPY: begin
                            if (we) begin
                                copyDataQ <= wordBD;
                                copyAddrQ <= address_a;
                                stateQ    <= COPY2;
                                busyQ     <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                COPY2: begin
                    if (inRangeCopyD) memQ[copyAddrQ] <= copyDataQ;
                    dataOutQ <= copyDataQ;
                    validQ   <= 1'b1;
                    stateQ   <= IDLE;
                    busyQ    <= 1'b0;
                end
                default: begin
                    stateQ  <= CLEAR;
                    clrCntQ <= '0;
                    busyQ   <= 1'b1;
                end
            endcase
        end
    end

    assign dataOut = dataOutQ;
    assign valid   = validQ;
    assign busy    = busyQ;

endmodule

// File: tb/tb_veda_mem_3.sv
// Directed scoreboard bench for veda_mem_3: a full-depth instance and a
// 40-word instance that exercises out-of-range addressing.
module tb_veda_mem_3;

    localparam logic [1:0] RD = 2'b00;
    localparam logic [1:0] WR = 2'b01;
    localparam logic [1:0] AC = 2'b10;
    localparam logic [1:0] CP = 2'b11;

    logic       clk = 1'b0;
    logic       rst0 = 1'b0;
    logic       rst1 = 1'b0;
    logic       we = 1'b0;
    logic [1:0] Mode = 2'b00;
    logic [5:0] addrA = '0;
    logic [5:0] addrB = '0;
    logic [7:0] dataIn = '0;

    logic [7:0] dataOut0, dataOut1;
    logic       valid0, valid1;
    logic       busy0, busy1;

    int         tgt = 0;
    int         assertCount = 0;
    int         failCount = 0;
    logic [7:0] expQ [$];
    logic [7:0] lastData = '0;

    // Free-running 10 ns clock shared by both instances.
    always #5 clk = ~clk;

    veda_mem_3 #(.DATA_W(8), .ADDR_W(6), .DEPTH(64)) dut0 (
        .clk(clk), .rst(rst0), .we(we), .Mode(Mode),
        .address_a(addrA), .address_b(addrB), .dataIn(dataIn),
        .dataOut(dataOut0), .valid(valid0), .busy(busy0)
    );

    veda_mem_3 #(.DATA_W(8), .ADDR_W(6), .DEPTH(40)) dut1 (
        .clk(clk), .rst(rst1), .we(we), .Mode(Mode),
        .address_a(addrA), .address_b(addrB), .dataIn(dataIn),
        .dataOut(dataOut1), .valid(valid1), .busy(busy1)
    );

    // Drive one command; the non-targeted instance is held in reset.
    task automatic applyStimulus(input logic r, input logic [1:0] m, input logic w,
                                 input logic [5:0] a, input logic [5:0] b,
                                 input logic [7:0] d, input logic push,
                                 input logic [7:0] pushData);
        if (tgt == 0) begin
            rst0 = r;
            rst1 = 1'b0;
        end else begin
            rst1 = r;
            rst0 = 1'b0;
        end
        Mode   = m;
        we     = w;
        addrA  = a;
        addrB  = b;
        dataIn = d;
        if (!r) begin
            expQ.delete();
            lastData = '0;
        end
        if (push) expQ.push_back(pushData);
    endtask

    // Compare the targeted instance's outputs one delta after the active edge.
    task automatic checkOutput(input string tag, input logic expValid, input logic expBusy);
        logic [7:0] obsData;
        logic       obsValid;
        logic       obsBusy;
        logic [7:0] expData;
        obsData  = (tgt == 0) ? dataOut0 : dataOut1;
        obsValid = (tgt == 0) ? valid0   : valid1;
        obsBusy  = (tgt == 0) ? busy0    : busy1;

        assertCount++;
        assert (obsValid === expValid) else begin
            failCount++;
            $error("FAIL %s valid: observed %b expected %b", tag, obsValid, expValid);
        end
        assertCount++;
        assert (obsBusy === expBusy) else begin
            failCount++;
            $error("FAIL %s busy: observed %b expected %b", tag, obsBusy, expBusy);
        end
        if (obsValid === 1'b1) begin
            assertCount++;
            assert (expQ.size() > 0) else begin
                failCount++;
                $error("FAIL %s scoreboard: observed valid pulse, expected no pending result", tag);
            end
            if (expQ.size() > 0) begin
                expData = expQ.pop_front();
                lastData = expData;
                assertCount++;
                assert (obsData === expData) else begin
                    failCount++;
                    $error("FAIL %s dataOut: observed %h expected %h", tag, obsData, expData);
                end
            end
        end else begin
            assertCount++;
            assert (obsData === lastData) else begin
                failCount++;
                $error("FAIL %s dataOut hold: observed %h expected %h", tag, obsData, lastData);
            end
        end
    endtask

    task automatic cycle(input string tag, input logic r, input logic [1:0] m, input logic w,
                         input logic [5:0] a, input logic [5:0] b, input logic [7:0] d,
                         input logic push, input logic [7:0] pushData,
                         input logic expValid, input logic expBusy);
        applyStimulus(r, m, w, a, b, d, push, pushData);
        @(posedge clk);
        #1;
        checkOutput(tag, expValid, expBusy);
    endtask

    initial begin
        // Full-depth instance: reset and clear, with a write held on the inputs throughout.
        tgt = 0;
        cycle("rst0_a", 1'b0, RD, 1'b0, 6'd0, 6'd0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        cycle("rst0_b", 1'b0, RD, 1'b0, 6'd0, 6'd0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 1; i <= 64; i++)
            cycle("clear0", 1'b1, WR, 1'b1, 6'd5, 6'd5, 8'hEE, 1'b0, 8'h00, 1'b0, (i < 64));

        cycle("read20_clr", 1'b1, RD, 1'b0, 6'd0, 6'd20, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        cycle("read5_clr",  1'b1, RD, 1'b0, 6'd0, 6'd5,  8'h00, 1'b1, 8'h00, 1'b1, 1'b0);

        // Write-with-read returns the old word at a colliding address.
        cycle("wr_rbw",     1'b1, WR, 1'b1, 6'd20, 6'd20, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0);
        cycle("read20_55",  1'b1, RD, 1'b0, 6'd0,  6'd20, 8'h00, 1'b1, 8'h55, 1'b1, 1'b0);
        cycle("wr_we0",     1'b1, WR, 1'b0, 6'd20, 6'd0,  8'h57, 1'b1, 8'h00, 1'b1, 1'b0);
        cycle("read20_kept",1'b1, RD, 1'b0, 6'd0,  6'd20, 8'h00, 1'b1, 8'h55, 1'b1, 1'b0);

        // Back-to-back accumulate with carry discarded.
        cycle("acc_1",      1'b1, AC, 1'b1, 6'd20, 6'd0, 8'hF0, 1'b1, 8'h45, 1'b1, 1'b0);
        cycle("acc_2",      1'b1, AC, 1'b1, 6'd20, 6'd0, 8'hF0, 1'b1, 8'h35, 1'b1, 1'b0);
        cycle("acc_we0",    1'b1, AC, 1'b0, 6'd20, 6'd0, 8'hF0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Copy: one busy cycle, then the result; a write offered meanwhile is dropped.
        cycle("copy_we0",   1'b1, CP, 1'b0, 6'd26, 6'd20, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        cycle("copy_issue", 1'b1, CP, 1'b1, 6'd26, 6'd20, 8'h00, 1'b1, 8'h35, 1'b0, 1'b1);
        cycle("copy_done",  1'b1, WR, 1'b1, 6'd26, 6'd26, 8'h99, 1'b0, 8'h00, 1'b1, 1'b0);
        cycle("read26",     1'b1, RD, 1'b0, 6'd0,  6'd26, 8'h00, 1'b1, 8'h35, 1'b1, 1'b0);
        cycle("read20_src", 1'b1, RD, 1'b0, 6'd0,  6'd20, 8'h00, 1'b1, 8'h35, 1'b1, 1'b0);

        // Reset during the second copy cycle discards the pending write and reclears.
        cycle("copy2_issue",1'b1, CP, 1'b1, 6'd23, 6'd20, 8'h00, 1'b1, 8'h35, 1'b0, 1'b1);
        cycle("copy2_rst",  1'b0, RD, 1'b0, 6'd0,  6'd0,  8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 1; i <= 64; i++)
            cycle("reclear0", 1'b1, RD, 1'b0, 6'd0, 6'd0, 8'h00, 1'b0, 8'h00, 1'b0, (i < 64));
        cycle("read23",     1'b1, RD, 1'b0, 6'd0, 6'd23, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        cycle("read20_rc",  1'b1, RD, 1'b0, 6'd0, 6'd20, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        cycle("read26_rc",  1'b1, RD, 1'b0, 6'd0, 6'd26, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);

        // 40-word instance: shorter clear and out-of-range addressing.
        tgt = 1;
        cycle("rst1_a", 1'b0, RD, 1'b0, 6'd0, 6'd0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        cycle("rst1_b", 1'b0, RD, 1'b0, 6'd0, 6'd0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 1; i <= 40; i++)
            cycle("clear1", 1'b1, RD, 1'b0, 6'd0, 6'd0, 8'h00, 1'b0, 8'h00, 1'b0, (i < 40));
        cycle("oor_wr45",   1'b1, WR, 1'b1, 6'd45, 6'd39, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0);
        cycle("wr39_rd45",  1'b1, WR, 1'b1, 6'd39, 6'd45, 8'h11, 1'b1, 8'h00, 1'b1, 1'b0);
        cycle("oor_rd45",   1'b1, RD, 1'b0, 6'd0,  6'd45, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        cycle("read39",     1'b1, RD, 1'b0, 6'd0,  6'd39, 8'h00, 1'b1, 8'h11, 1'b1, 1'b0);
        cycle("oor_acc45",  1'b1, AC, 1'b1, 6'd45, 6'd0,  8'h05, 1'b1, 8'h05, 1'b1, 1'b0);
        cycle("oor_rd45_b", 1'b1, RD, 1'b0, 6'd0,  6'd45, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);

        assertCount++;
        assert (expQ.size() == 0) else begin
            failCount++;
            $error("FAIL scoreboard_drain: observed %0d pending results, expected 0", expQ.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
